// File: rtl/timer_bank_if.sv
// timer_bank_if: configuration, control and status bundle for timer_bank
interface timer_bank_if #(
  parameter int N_CH = 4,
  parameter int W = 8
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic en;
  logic cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0] cfg_reload;
  logic cfg_auto;
  logic [N_CH-1:0] start;
  logic [N_CH-1:0] stop;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] done;
  logic [N_CH*W-1:0] count;
  modport master (
    output en, cfg_we, cfg_ch, cfg_reload, cfg_auto, start, stop,
    input busy, done, count
  );
  modport slave (
    input en, cfg_we, cfg_ch, cfg_reload, cfg_auto, start, stop,
    output busy, done, count
  );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: N_CH independent programmable down-counters sharing a prescaled tick
module timer_bank #(
  parameter int N_CH = 4,
  parameter int W = 8,
  parameter int PRESC = 1
) (
  input logic clk,
  input logic rst_n,
  timer_bank_if.slave bus
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);
  typedef enum logic {IDLE, RUN} state_t;
  logic [PW-1:0] presc;
  logic tick;
  assign tick = bus.en && presc == PLAST;
  // free-running prescaler, holds while disabled and is never touched by start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) presc <= '0;
    else if (bus.en) presc <= presc == PLAST ? '0 : presc + PW'(1);
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t state, state_n;
    logic [W-1:0] cnt, cnt_n, reload;
    logic auto_rl, done_q, done_n;
    assign bus.busy[c] = state == RUN;
    assign bus.done[c] = done_q;
    assign bus.count[c*W +: W] = cnt;
    // stop beats start beats tick; a zero reload pulses done without entering RUN
    always_comb begin
      state_n = state;
      cnt_n = cnt;
      done_n = 1'b0;
      if (bus.stop[c]) state_n = IDLE;
      else if (bus.start[c]) begin
        cnt_n = reload;
        done_n = reload == '0;
        state_n = reload == '0 ? IDLE : RUN;
      end else if (tick && state == RUN) begin
        done_n = cnt <= W'(1);
        cnt_n = cnt > W'(1) ? cnt - W'(1) : auto_rl ? reload : '0;
        state_n = cnt > W'(1) || (auto_rl && reload != '0) ? RUN : IDLE;
      end
    end
    // channel state plus its config; start above sees reload before this edge's write
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state <= IDLE;
        cnt <= '0;
        done_q <= 1'b0;
        reload <= '0;
        auto_rl <= 1'b0;
      end else begin
        state <= state_n;
        cnt <= cnt_n;
        done_q <= done_n;
        if (bus.cfg_we && bus.cfg_ch == CW'(c)) begin
          reload <= bus.cfg_reload;
          auto_rl <= bus.cfg_auto;
        end
      end
  end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: randomized scoreboard bench for two timer_bank configurations
module tb_timer_bank;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  timer_bank_if #(.N_CH(4), .W(W)) ia ();
  timer_bank_if #(.N_CH(3), .W(W)) ib ();
  timer_bank #(.N_CH(4), .W(W), .PRESC(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  timer_bank #(.N_CH(3), .W(W), .PRESC(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  typedef struct packed {
    logic [3:0] busy;
    logic [3:0] done;
    logic [31:0] count;
  } obs_t;
  typedef struct {
    obs_t a;
    obs_t b;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  int nch[2] = '{4, 3};
  int pr[2] = '{1, 4};
  int m_pc[2];
  int m_cnt[2][4];
  int m_rl[2][4];
  bit m_run[2][4];
  bit m_auto[2][4];
  bit m_done[2][4];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[d][i] = 0;
        m_rl[d][i] = 0;
        m_run[d][i] = 0;
        m_auto[d][i] = 0;
        m_done[d][i] = 0;
      end
    end
  endfunction

  function automatic void model(bit en, bit we, int ch, int rl, bit au, logic [3:0] st, logic [3:0] sp);
    bit tick;
    for (int d = 0; d < 2; d++) begin
      tick = en && m_pc[d] == pr[d] - 1;
      if (en) m_pc[d] = (m_pc[d] + 1) % pr[d];
      for (int i = 0; i < nch[d]; i++) begin
        m_done[d][i] = 0;
        if (sp[i]) m_run[d][i] = 0;
        else if (st[i]) begin
          m_cnt[d][i] = m_rl[d][i];
          m_run[d][i] = m_rl[d][i] != 0;
          m_done[d][i] = m_rl[d][i] == 0;
        end else if (tick && m_run[d][i]) begin
          if (m_cnt[d][i] > 1) m_cnt[d][i] = m_cnt[d][i] - 1;
          else begin
            m_done[d][i] = 1;
            m_cnt[d][i] = m_auto[d][i] ? m_rl[d][i] : 0;
            m_run[d][i] = m_cnt[d][i] != 0;
          end
        end
      end
      if (we && ch < nch[d]) begin
        m_rl[d][ch] = rl;
        m_auto[d][ch] = au;
      end
    end
  endfunction

  function automatic obs_t snap(int d);
    obs_t o;
    o = '0;
    for (int i = 0; i < nch[d]; i++) begin
      o.busy[i] = m_run[d][i];
      o.done[i] = m_done[d][i];
      o.count[i*W +: W] = W'(m_cnt[d][i]);
    end
    return o;
  endfunction

  task automatic drive(bit en, bit we, int ch, int rl, bit au, logic [3:0] st, logic [3:0] sp);
    ia.en = en; ib.en = en;
    ia.cfg_we = we; ib.cfg_we = we;
    ia.cfg_ch = 2'(ch); ib.cfg_ch = 2'(ch);
    ia.cfg_reload = W'(rl); ib.cfg_reload = W'(rl);
    ia.cfg_auto = au; ib.cfg_auto = au;
    ia.start = st; ib.start = st[2:0];
    ia.stop = sp; ib.stop = sp[2:0];
  endtask

  task automatic cyc(bit en, bit we = 0, int ch = 0, int rl = 0, bit au = 0,
                     logic [3:0] st = 4'h0, logic [3:0] sp = 4'h0);
    exp_t x;
    @(negedge clk);
    #1;
    drive(en, we, ch, rl, au, st, sp);
    model(en, we, ch, rl, au, st, sp);
    x.a = snap(0);
    x.b = snap(1);
    sb.push_back(x);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".a.busy"}, 32'(ia.busy), 0);
    chk({tag, ".a.done"}, 32'(ia.done), 0);
    chk({tag, ".a.count"}, 32'(ia.count), 0);
    chk({tag, ".b.busy"}, 32'(ib.busy), 0);
    chk({tag, ".b.done"}, 32'(ib.done), 0);
    chk({tag, ".b.count"}, 32'(ib.count), 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 4'h0, 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // scoreboard monitor: one expected snapshot per clock, compared mid-cycle
  always @(negedge clk)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("a.busy", 32'(ia.busy), 32'(e.a.busy));
      chk("a.done", 32'(ia.done), 32'(e.a.done));
      chk("a.count", 32'(ia.count), e.a.count);
      chk("b.busy", 32'(ib.busy), 32'(e.b.busy));
      chk("b.done", 32'(ib.done), 32'(e.b.done));
      chk("b.count", 32'(ib.count), e.b.count);
    end

  initial begin
    logic [3:0] st, sp;
    drive(0, 0, 0, 0, 0, 4'h0, 4'h0);
    model_reset();
    #3 chk_zero("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(1); cyc(1, 0, 0, 0, 0, 4'b0001); cyc(1); cyc(1);
    cyc(1, 1, 0, 5, 0); cyc(1, 0, 0, 0, 0, 4'b0001); repeat (8) cyc(1);
    cyc(1, 1, 1, 3, 1); cyc(1, 0, 0, 0, 0, 4'b0010);
    repeat (30) cyc(1); repeat (5) cyc(0); repeat (20) cyc(1);
    cyc(1, 1, 2, 10, 0); cyc(1, 0, 0, 0, 0, 4'b0100); repeat (6) cyc(1);
    cyc(1, 0, 0, 0, 0, 4'b0100, 4'b0100); repeat (3) cyc(1);
    cyc(1, 0, 0, 0, 0, 4'b0100); repeat (4) cyc(1);
    cyc(1, 1, 3, 7, 1); cyc(1, 0, 0, 0, 0, 4'b1000); repeat (3) cyc(1);
    cyc(1, 1, 3, 2, 1); repeat (12) cyc(1);
    cyc(1, 1, 3, 0, 1); repeat (10) cyc(1);
    for (int i = 0; i < 4; i++) cyc(1, 1, i, 4, 0);
    cyc(1, 0, 0, 0, 0, 4'hF); repeat (20) cyc(1);
    cyc(1, 0, 0, 0, 0, 4'hF); repeat (2) cyc(1);
    mid_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        st[i] = $urandom_range(0, 15) == 0;
        sp[i] = $urandom_range(0, 31) == 0;
      end
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3),
          $urandom_range(0, 7), 1'($urandom_range(0, 1)), st, sp);
      if (n % 1000 == 999) mid_reset();
    end
    cyc(1);
    @(negedge clk);
    #2 chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
